// File: rtl/render_pkg.sv
// Shared constants and character state type for the per-pixel render scheduler.
package render_pkg;

  localparam logic [1:0] MEM_SEL_CHAR = 2'b11;
  localparam logic [1:0] MEM_SEL_MAP  = 2'b01;
  localparam logic [1:0] MEM_SEL_NONE = 2'b00;
  localparam int         TILE_W       = 8;
  localparam int         CHAR_W       = 8;

  typedef struct packed {
    logic       en;
    logic [9:0] x;
    logic [9:0] y;
    logic [7:0] code;
  } char_state_t;

endpackage

// File: rtl/render_scheduler_if.sv
// Scan-position stream, character state, map RAM port and per-pixel render outputs.
interface render_scheduler_if #(parameter int NUM_CHAR = 4);

  logic                  i_pix_valid;
  logic [9:0]            i_x;
  logic [9:0]            i_y;
  logic                  i_frame_start;
  logic [NUM_CHAR-1:0]   i_char_en;
  logic [NUM_CHAR*10-1:0] i_char_x;
  logic [NUM_CHAR*10-1:0] i_char_y;
  logic [NUM_CHAR*8-1:0] i_char_code;
  logic [9:0]            o_map_rd_addr;
  logic [4:0]            i_map_rd_data;
  logic                  o_valid;
  logic [1:0]            o_mem_select;
  logic [4:0]            o_address_map;
  logic [7:0]            o_address_char;
  logic [5:0]            o_tile_offset;
  logic [5:0]            o_char_offset;

  modport master (
    output i_pix_valid, i_x, i_y, i_frame_start, i_char_en, i_char_x, i_char_y,
           i_char_code, i_map_rd_data,
    input  o_map_rd_addr, o_valid, o_mem_select, o_address_map, o_address_char,
           o_tile_offset, o_char_offset
  );

  modport slave (
    input  i_pix_valid, i_x, i_y, i_frame_start, i_char_en, i_char_x, i_char_y,
           i_char_code, i_map_rd_data,
    output o_map_rd_addr, o_valid, o_mem_select, o_address_map, o_address_char,
           o_tile_offset, o_char_offset
  );

endinterface

// File: rtl/char_hit_check.sv
// Combinational test of one pixel against one 8x8 character box; wraps modulo 1024.
module char_hit_check
  import render_pkg::*;
(
  input  logic [9:0]  pix_x,
  input  logic [9:0]  pix_y,
  input  char_state_t chr,
  output logic        hit,
  output logic [2:0]  dx,
  output logic [2:0]  dy
);

  logic [9:0] ddx;
  logic [9:0] ddy;

  assign ddx = pix_x - chr.x;
  assign ddy = pix_y - chr.y;
  assign hit = chr.en && (ddx < 10'(CHAR_W)) && (ddy < 10'(CHAR_W));
  assign dx  = ddx[2:0];
  assign dy  = ddy[2:0];

endmodule

// File: rtl/render_scheduler.sv
// Per-pixel character/map priority scheduler, fixed 2-cycle latency, never back-pressures.
module render_scheduler
  import render_pkg::*;
#(
  parameter int NUM_CHAR = 4,
  parameter int MAP_COLS = 28,
  parameter int MAP_ROWS = 31,
  parameter int ORG_X    = 208,
  parameter int ORG_Y    = 116
) (
  input  logic              i_clk,
  input  logic              i_rst,
  render_scheduler_if.slave bus
);

  char_state_t          shadow [NUM_CHAR];
  logic [NUM_CHAR-1:0]  hit;
  logic [2:0]           hit_dx [NUM_CHAR];
  logic [2:0]           hit_dy [NUM_CHAR];

  // Character state only changes at frame boundaries; same-cycle pixels see the old copy.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int k = 0; k < NUM_CHAR; k++) shadow[k] <= '0;
    end else if (bus.i_frame_start) begin
      for (int k = 0; k < NUM_CHAR; k++) begin
        shadow[k].en   <= bus.i_char_en[k];
        shadow[k].x    <= bus.i_char_x[k*10 +: 10];
        shadow[k].y    <= bus.i_char_y[k*10 +: 10];
        shadow[k].code <= bus.i_char_code[k*8 +: 8];
      end
    end
  end

  for (genvar k = 0; k < NUM_CHAR; k++) begin : g_hit
    char_hit_check u_hit (
      .pix_x (bus.i_x),
      .pix_y (bus.i_y),
      .chr   (shadow[k]),
      .hit   (hit[k]),
      .dx    (hit_dx[k]),
      .dy    (hit_dy[k])
    );
  end

  logic [10:0] rx;
  logic [10:0] ry;
  logic        in_field;
  logic [9:0]  map_addr;
  logic [9:0]  addr_q;
  logic        addr_upd;

  assign rx       = {1'b0, bus.i_x} - 11'(ORG_X);
  assign ry       = {1'b0, bus.i_y} - 11'(ORG_Y);
  assign in_field = !rx[10] && !ry[10] &&
                    (rx[9:0] < 10'(MAP_COLS*TILE_W)) && (ry[9:0] < 10'(MAP_ROWS*TILE_W));
  assign map_addr = 10'(ry[7:3]) * 10'(MAP_COLS) + 10'(rx[7:3]);
  assign addr_upd = bus.i_pix_valid && in_field && !i_rst;

  // Address is held between in-field pixels so the RAM port does not toggle needlessly.
  assign bus.o_map_rd_addr = addr_upd ? map_addr : addr_q;

  logic       sel_hit;
  logic [7:0] sel_code;
  logic [5:0] sel_off;

  always_comb begin
    sel_hit  = 1'b0;
    sel_code = '0;
    sel_off  = '0;
    for (int k = NUM_CHAR-1; k >= 0; k--) begin
      if (hit[k]) begin
        sel_hit  = 1'b1;
        sel_code = shadow[k].code;
        sel_off  = {hit_dy[k], hit_dx[k]};
      end
    end
  end

  logic       s1_vld;
  logic       s1_hit;
  logic       s1_in_field;
  logic [7:0] s1_code;
  logic [5:0] s1_char_off;
  logic [5:0] s1_tile_off;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      addr_q      <= '0;
      s1_vld      <= 1'b0;
      s1_hit      <= 1'b0;
      s1_in_field <= 1'b0;
      s1_code     <= '0;
      s1_char_off <= '0;
      s1_tile_off <= '0;
    end else begin
      if (addr_upd) addr_q <= map_addr;
      s1_vld      <= bus.i_pix_valid;
      s1_hit      <= sel_hit;
      s1_in_field <= in_field;
      s1_code     <= sel_code;
      s1_char_off <= sel_off;
      s1_tile_off <= {ry[2:0], rx[2:0]};
    end
  end

  logic       nx_valid;
  logic [1:0] nx_sel;
  logic [4:0] nx_amap;
  logic [7:0] nx_achar;
  logic [5:0] nx_toff;
  logic [5:0] nx_coff;

  always_comb begin
    nx_valid = 1'b0;
    nx_sel   = MEM_SEL_NONE;
    nx_amap  = '0;
    nx_achar = '0;
    nx_toff  = '0;
    nx_coff  = '0;
    if (s1_vld) begin
      nx_valid = 1'b1;
      if (s1_hit) begin
        nx_sel   = MEM_SEL_CHAR;
        nx_achar = s1_code;
        nx_coff  = s1_char_off;
      end else if (s1_in_field) begin
        nx_sel  = MEM_SEL_MAP;
        nx_amap = bus.i_map_rd_data;
        nx_toff = s1_tile_off;
      end
    end
  end

  logic       o_valid_q;
  logic [1:0] o_sel_q;
  logic [4:0] o_amap_q;
  logic [7:0] o_achar_q;
  logic [5:0] o_toff_q;
  logic [5:0] o_coff_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_valid_q <= 1'b0;
      o_sel_q   <= MEM_SEL_NONE;
      o_amap_q  <= '0;
      o_achar_q <= '0;
      o_toff_q  <= '0;
      o_coff_q  <= '0;
    end else begin
      o_valid_q <= nx_valid;
      o_sel_q   <= nx_sel;
      o_amap_q  <= nx_amap;
      o_achar_q <= nx_achar;
      o_toff_q  <= nx_toff;
      o_coff_q  <= nx_coff;
    end
  end

  assign bus.o_valid        = o_valid_q;
  assign bus.o_mem_select   = o_sel_q;
  assign bus.o_address_map  = o_amap_q;
  assign bus.o_address_char = o_achar_q;
  assign bus.o_tile_offset  = o_toff_q;
  assign bus.o_char_offset  = o_coff_q;

endmodule

// File: tb/tb_render_scheduler.sv
// Directed plus randomized bench for render_scheduler against a behavioural pixel model.
module tb_render_scheduler;

  localparam int NC = 4;

  logic clk = 1'b0;
  logic rst;

  render_scheduler_if #(.NUM_CHAR(NC)) bus ();

  render_scheduler #(
    .NUM_CHAR (NC),
    .MAP_COLS (28),
    .MAP_ROWS (31),
    .ORG_X    (208),
    .ORG_Y    (116)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [4:0] map_ram [1024];
  always @(posedge clk) bus.i_map_rd_data <= map_ram[bus.o_map_rd_addr];

  typedef struct packed {
    logic       vld;
    logic [1:0] sel;
    logic [4:0] amap;
    logic [7:0] achar;
    logic [5:0] toff;
    logic [5:0] coff;
  } exp_t;

  exp_t hist [4096];
  int   checks   = 0;
  int   failures = 0;
  int   n        = 0;

  // Stimulus for the next step, and the model's own copy of the latched character state.
  logic pv, fs, rs;
  int   px, py;
  int   cen [NC], cx [NC], cy [NC], cc [NC];
  int   m_en [NC], m_x [NC], m_y [NC], m_code [NC];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s step=%0d observed=%0h expected=%0h", tag, n, obs, expv);
    end
  endtask

  function automatic exp_t model(input int x, input int y);
    exp_t e;
    int   rx, ry;
    e  = '0;
    rx = x - 208;
    ry = y - 116;
    e.vld = 1'b1;
    for (int k = 0; k < NC; k++) begin
      int dx, dy;
      dx = (x - m_x[k]) & 1023;
      dy = (y - m_y[k]) & 1023;
      if (m_en[k] != 0 && dx < 8 && dy < 8) begin
        e.sel   = 2'b11;
        e.achar = 8'(m_code[k]);
        e.coff  = 6'(dy * 8 + dx);
        return e;
      end
    end
    if (rx >= 0 && ry >= 0 && rx < 224 && ry < 248) begin
      e.sel  = 2'b01;
      e.amap = map_ram[(ry / 8) * 28 + rx / 8];
      e.toff = 6'((ry % 8) * 8 + rx % 8);
    end
    return e;
  endfunction

  task automatic drive();
    bus.i_pix_valid   = pv;
    bus.i_x           = 10'(px);
    bus.i_y           = 10'(py);
    bus.i_frame_start = fs;
    rst               = rs;
    for (int k = 0; k < NC; k++) begin
      bus.i_char_en[k]         = (cen[k] != 0);
      bus.i_char_x[k*10 +: 10] = 10'(cx[k]);
      bus.i_char_y[k*10 +: 10] = 10'(cy[k]);
      bus.i_char_code[k*8 +: 8] = 8'(cc[k]);
    end
  endtask

  task automatic step();
    exp_t e;
    int   exp_addr;
    logic addr_chk;
    @(posedge clk);
    #1;
    drive();
    e        = pv ? model(px, py) : '0;
    addr_chk = pv && !rs && (px - 208) >= 0 && (py - 116) >= 0 && (px - 208) < 224 && (py - 116) < 248;
    exp_addr = ((py - 116) / 8) * 28 + (px - 208) / 8;
    if (rs) begin
      e = '0;
      if (n > 0) hist[n-1] = '0;
      for (int k = 0; k < NC; k++) begin
        m_en[k] = 0; m_x[k] = 0; m_y[k] = 0; m_code[k] = 0;
      end
    end else if (fs) begin
      for (int k = 0; k < NC; k++) begin
        m_en[k] = cen[k]; m_x[k] = cx[k]; m_y[k] = cy[k]; m_code[k] = cc[k];
      end
    end
    hist[n] = e;
    @(negedge clk);
    if (addr_chk) check("map_rd_addr", 32'(bus.o_map_rd_addr), 32'(exp_addr));
    if (n >= 2) begin
      check("valid",        32'(bus.o_valid),        32'(hist[n-2].vld));
      check("mem_select",   32'(bus.o_mem_select),   32'(hist[n-2].sel));
      check("address_map",  32'(bus.o_address_map),  32'(hist[n-2].amap));
      check("address_char", 32'(bus.o_address_char), 32'(hist[n-2].achar));
      check("tile_offset",  32'(bus.o_tile_offset),  32'(hist[n-2].toff));
      check("char_offset",  32'(bus.o_char_offset),  32'(hist[n-2].coff));
    end
    n++;
  endtask

  task automatic pix(input int x, input int y);
    pv = 1'b1; px = x; py = y;
    step();
  endtask

  task automatic idle(input int cycles);
    pv = 1'b0;
    for (int i = 0; i < cycles; i++) step();
  endtask

  task automatic set_char(input int k, input int en, input int x, input int y, input int code);
    cen[k] = en; cx[k] = x; cy[k] = y; cc[k] = code;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) map_ram[i] = 5'($urandom);
    bus.i_map_rd_data = '0;
    pv = 1'b0; fs = 1'b0; rs = 1'b1; px = 0; py = 0;
    for (int k = 0; k < NC; k++) begin
      set_char(k, 0, 0, 0, 0);
      m_en[k] = 0; m_x[k] = 0; m_y[k] = 0; m_code[k] = 0;
    end
    drive();

    // Reset, then first in-field pixel at the playfield origin.
    idle(5);
    rs = 1'b0;
    idle(2);
    pix(208, 116);
    pix(100, 50);
    idle(2);

    // Single character latched at a frame boundary.
    set_char(0, 1, 300, 200, 8'h04);
    fs = 1'b1; idle(1); fs = 1'b0;
    pix(303, 205);
    idle(2);

    // Overlap: char0 wins, then char0 disabled leaves char2 visible.
    set_char(0, 1, 306, 206, 8'h04);
    set_char(2, 1, 305, 205, 8'h22);
    fs = 1'b1; idle(1); fs = 1'b0;
    pix(310, 210);
    set_char(0, 0, 306, 206, 8'h04);
    fs = 1'b1; idle(1); fs = 1'b0;
    pix(310, 210);

    // Mid-frame input change ignored; coincident frame_start pixel uses old state.
    set_char(2, 1, 0, 0, 8'h22);
    pix(310, 210);
    fs = 1'b1; pix(310, 210); fs = 1'b0;
    pix(310, 210);
    pix(2, 3);
    idle(2);

    // Randomized frames and pixels, biased toward character boxes and field edges.
    for (int i = 0; i < 400; i++) begin
      fs = ($urandom_range(0, 24) == 0);
      if (fs) begin
        for (int k = 0; k < NC; k++)
          set_char(k, int'($urandom_range(0, 3) != 0), int'($urandom_range(180, 460)),
                   int'($urandom_range(100, 380)), int'($urandom_range(0, 255)));
      end
      pv = ($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 1) == 0) begin
        int k;
        k  = int'($urandom_range(0, NC-1));
        px = (m_x[k] + int'($urandom_range(0, 10)) - 1) & 1023;
        py = (m_y[k] + int'($urandom_range(0, 10)) - 1) & 1023;
      end else begin
        px = int'($urandom_range(190, 450));
        py = int'($urandom_range(100, 380));
      end
      step();
    end
    fs = 1'b0;

    // Stream with a 3-cycle gap, then reset mid-stream with characters still presented.
    set_char(1, 1, 250, 150, 8'h5a);
    fs = 1'b1; idle(1); fs = 1'b0;
    for (int i = 0; i < 8; i++) pix(248 + i, 150 + i);
    idle(3);
    for (int i = 0; i < 5; i++) pix(250 + i, 152);
    rs = 1'b1; pix(251, 153); rs = 1'b0;
    for (int i = 0; i < 8; i++) pix(250 + i, 150 + i);
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
